// File: rtl/game_pkg.sv
// Shared types and constants for the cat-and-dog game turn logic.
package game_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_READY,
    LOCAL_AIM,
    LOCAL_CHARGE,
    LOCAL_THROW,
    LOCAL_FLIGHT,
    REMOTE_WAIT,
    REMOTE_FLIGHT,
    GAME_OVER
  } turn_state_t;

  localparam int POWER_W = 5;
  localparam logic [POWER_W-1:0] POWER_MAX = 5'd31;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  // Four-LED bar: one more LED lights for every two steps of the coarse level.
  function automatic logic [3:0] charge_bar(input logic [2:0] level);
    logic [3:0] bar;
    case (level)
      3'd0:          bar = 4'b0000;
      3'd1, 3'd2:    bar = 4'b0001;
      3'd3, 3'd4:    bar = 4'b0011;
      3'd5, 3'd6:    bar = 4'b0111;
      default:       bar = 4'b1111;
    endcase
    return bar;
  endfunction

endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer for signals arriving from the remote board.
module link_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/turn_ctl.sv
// Game-turn sequencer: link handshake, turn alternation, power charging
// and throw launch for one board of the two-board throwing game.
module turn_ctl
  import game_pkg::*;
#(
  parameter int CHARGE_DIV = 1_200_000,
  parameter int FLAG_HOLD  = 64,
  parameter int WIN_HITS   = 4
) (
  input  logic               clk60MHz,
  input  logic               rst,
  input  logic               player1_choose,
  input  logic               player2_choose,
  input  logic               mouse_left,
  input  logic               in_player1_ready,
  input  logic               in_player2_ready,
  input  logic [POWER_W-1:0] in_power,
  input  logic               in_throw_flag,
  input  logic               throw_done,
  input  logic               throw_hit,
  output logic               out_player1_ready,
  output logic               out_player2_ready,
  output logic [POWER_W-1:0] out_power,
  output logic               out_throw_flag,
  output logic               player1_led,
  output logic               player2_led,
  output logic [3:0]         ledy,
  output logic               turn,
  output logic               throw_start,
  output logic [POWER_W-1:0] throw_power,
  output logic [1:0]         winner
);

  localparam int DIV_W  = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam int HOLD_W = (FLAG_HOLD > 1) ? $clog2(FLAG_HOLD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CHARGE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FLAG_HOLD - 1);
  localparam logic [2:0]        WIN_CNT   = 3'(WIN_HITS);

  logic [1:0]         readySync;
  logic [POWER_W-1:0] powerSync;
  logic               flagSync;

  link_sync #(.WIDTH(2)) u_ready_sync (
    .clk_i (clk60MHz),
    .rst_i (rst),
    .d_i   ({in_player2_ready, in_player1_ready}),
    .q_o   (readySync)
  );

  link_sync #(.WIDTH(POWER_W)) u_power_sync (
    .clk_i (clk60MHz),
    .rst_i (rst),
    .d_i   (in_power),
    .q_o   (powerSync)
  );

  link_sync #(.WIDTH(1)) u_flag_sync (
    .clk_i (clk60MHz),
    .rst_i (rst),
    .d_i   (in_throw_flag),
    .q_o   (flagSync)
  );

  turn_state_t        state_q;
  logic               myRole_q;
  logic               turn_q;
  logic               mousePrev_q;
  logic               flagPrev_q;
  logic [DIV_W-1:0]   divCnt_q, divCnt_d;
  logic [POWER_W-1:0] power_q, power_d;
  logic [POWER_W-1:0] outPower_q;
  logic [POWER_W-1:0] throwPower_q;
  logic [HOLD_W-1:0]  holdCnt_q;
  logic [2:0]         hitsP1_q, hitsP2_q;
  logic               outFlag_q;
  logic               throwStart_q;
  logic               p1Ready_q, p2Ready_q;
  logic               p1Led_q, p2Led_q;
  logic [3:0]         ledy_q;
  winner_t            winner_q;

  logic               mouseRise;
  logic               flagRise;
  logic               remoteReady;
  logic [2:0]         throwerHits;
  logic [2:0]         hitsInc;
  logic               winReached;
  turn_state_t        afterFlight;

  always_comb begin
    mouseRise   = mouse_left & ~mousePrev_q;
    flagRise    = flagSync & ~flagPrev_q;
    remoteReady = myRole_q ? readySync[0] : readySync[1];
    throwerHits = turn_q ? hitsP2_q : hitsP1_q;
    hitsInc     = (throwerHits == 3'd7) ? 3'd7 : throwerHits + 3'd1;
    winReached  = (hitsInc >= WIN_CNT);
    afterFlight = ((~turn_q) == myRole_q) ? LOCAL_AIM : REMOTE_WAIT;
  end

  // Charge prescaler: a fresh press restarts from zero, holding counts up and saturates.
  always_comb begin
    divCnt_d = divCnt_q;
    power_d  = power_q;
    if (state_q == LOCAL_AIM && mouseRise) begin
      divCnt_d = '0;
      power_d  = '0;
    end else if (state_q == LOCAL_CHARGE && mouse_left) begin
      if (divCnt_q == DIV_LAST) begin
        divCnt_d = '0;
        if (power_q != POWER_MAX) begin
          power_d = power_q + POWER_W'(1);
        end
      end else begin
        divCnt_d = divCnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      myRole_q     <= 1'b0;
      turn_q       <= 1'b0;
      mousePrev_q  <= 1'b0;
      flagPrev_q   <= 1'b0;
      divCnt_q     <= '0;
      power_q      <= '0;
      outPower_q   <= '0;
      throwPower_q <= '0;
      holdCnt_q    <= '0;
      hitsP1_q     <= '0;
      hitsP2_q     <= '0;
      outFlag_q    <= 1'b0;
      throwStart_q <= 1'b0;
      p1Ready_q    <= 1'b0;
      p2Ready_q    <= 1'b0;
      p1Led_q      <= 1'b0;
      p2Led_q      <= 1'b0;
      ledy_q       <= '0;
      winner_q     <= WIN_NONE;
    end else begin
      mousePrev_q  <= mouse_left;
      flagPrev_q   <= flagSync;
      divCnt_q     <= divCnt_d;
      power_q      <= power_d;
      ledy_q       <= charge_bar(power_q[POWER_W-1:2]);
      throwStart_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (player1_choose ^ player2_choose) begin
            myRole_q  <= player2_choose;
            p1Ready_q <= player1_choose;
            p2Ready_q <= player2_choose;
            p1Led_q   <= player1_choose;
            p2Led_q   <= player2_choose;
            state_q   <= WAIT_READY;
          end
        end

        WAIT_READY: begin
          if (remoteReady) begin
            turn_q  <= 1'b0;
            state_q <= myRole_q ? REMOTE_WAIT : LOCAL_AIM;
          end
        end

        LOCAL_AIM: begin
          if (mouseRise) begin
            state_q <= LOCAL_CHARGE;
          end
        end

        LOCAL_CHARGE: begin
          if (!mouse_left) begin
            outPower_q <= power_q;
            holdCnt_q  <= '0;
            state_q    <= LOCAL_THROW;
          end
        end

        // out_power settles one cycle before the flag so the remote sample is stable.
        LOCAL_THROW: begin
          if (!outFlag_q) begin
            outFlag_q    <= 1'b1;
            throwStart_q <= 1'b1;
            throwPower_q <= outPower_q;
            holdCnt_q    <= '0;
          end else if (holdCnt_q == HOLD_LAST) begin
            outFlag_q <= 1'b0;
            state_q   <= LOCAL_FLIGHT;
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
          end
        end

        REMOTE_WAIT: begin
          if (flagRise) begin
            throwPower_q <= powerSync;
            throwStart_q <= 1'b1;
            state_q      <= REMOTE_FLIGHT;
          end
        end

        LOCAL_FLIGHT, REMOTE_FLIGHT: begin
          if (throw_done) begin
            if (throw_hit) begin
              if (turn_q) hitsP2_q <= hitsInc;
              else        hitsP1_q <= hitsInc;
            end
            if (throw_hit && winReached) begin
              winner_q <= turn_q ? WIN_P2 : WIN_P1;
              state_q  <= GAME_OVER;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= afterFlight;
            end
          end
        end

        GAME_OVER: begin
          state_q <= GAME_OVER;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_player1_ready = p1Ready_q;
  assign out_player2_ready = p2Ready_q;
  assign out_power         = outPower_q;
  assign out_throw_flag    = outFlag_q;
  assign player1_led       = p1Led_q;
  assign player2_led       = p2Led_q;
  assign ledy              = ledy_q;
  assign turn              = turn_q;
  assign throw_start       = throwStart_q;
  assign throw_power       = throwPower_q;
  assign winner            = winner_q;

endmodule

// File: tb/tb_turn_ctl.sv
// Scenario bench for turn_ctl: this board plays player1 against a scripted remote.
module tb_turn_ctl;

  localparam int CHARGE_DIV = 4;
  localparam int FLAG_HOLD  = 8;
  localparam int WIN_HITS   = 4;

  logic       clk60MHz = 1'b0;
  logic       rst;
  logic       player1_choose, player2_choose, mouse_left;
  logic       in_player1_ready, in_player2_ready;
  logic [4:0] in_power;
  logic       in_throw_flag, throw_done, throw_hit;
  logic       out_player1_ready, out_player2_ready;
  logic [4:0] out_power;
  logic       out_throw_flag, player1_led, player2_led;
  logic [3:0] ledy;
  logic       turn, throw_start;
  logic [4:0] throw_power;
  logic [1:0] winner;

  logic [22:0] allOut;
  assign allOut = {out_player1_ready, out_player2_ready, out_power, out_throw_flag,
                   player1_led, player2_led, ledy, turn, throw_start, throw_power, winner};

  int compared   = 0;
  int mismatched = 0;
  logic [4:0] expQ[$];

  always #5 clk60MHz = ~clk60MHz;

  turn_ctl #(
    .CHARGE_DIV (CHARGE_DIV),
    .FLAG_HOLD  (FLAG_HOLD),
    .WIN_HITS   (WIN_HITS)
  ) dut (
    .clk60MHz          (clk60MHz),
    .rst               (rst),
    .player1_choose    (player1_choose),
    .player2_choose    (player2_choose),
    .mouse_left        (mouse_left),
    .in_player1_ready  (in_player1_ready),
    .in_player2_ready  (in_player2_ready),
    .in_power          (in_power),
    .in_throw_flag     (in_throw_flag),
    .throw_done        (throw_done),
    .throw_hit         (throw_hit),
    .out_player1_ready (out_player1_ready),
    .out_player2_ready (out_player2_ready),
    .out_power         (out_power),
    .out_throw_flag    (out_throw_flag),
    .player1_led       (player1_led),
    .player2_led       (player2_led),
    .ledy              (ledy),
    .turn              (turn),
    .throw_start       (throw_start),
    .throw_power       (throw_power),
    .winner            (winner)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk60MHz);
      if (throw_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_cycles(input int n, output int starts, output int flags);
    starts = 0;
    flags  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk60MHz);
      if (throw_start === 1'b1) starts++;
      if (out_throw_flag === 1'b1) flags++;
    end
  endtask

  task automatic press_mouse(input int edges, output logic [4:0] expPower);
    int p;
    p = (edges - 1) / CHARGE_DIV;
    if (p > 31) p = 31;
    expPower = 5'(p);
    mouse_left = 1'b1;
    repeat (edges) @(negedge clk60MHz);
    mouse_left = 1'b0;
  endtask

  task automatic done_pulse(input logic hit);
    throw_done = 1'b1;
    throw_hit  = hit;
    @(negedge clk60MHz);
    throw_done = 1'b0;
    throw_hit  = 1'b0;
  endtask

  task automatic wait_flag_low(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_throw_flag !== 1'b1) break;
      @(negedge clk60MHz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    player1_choose = 0; player2_choose = 0; mouse_left = 0;
    in_player1_ready = 0; in_player2_ready = 0; in_power = '0;
    in_throw_flag = 0; throw_done = 0; throw_hit = 0;
    repeat (3) @(negedge clk60MHz);
    compared++;
    if (allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h required 0", allOut);
    end
    rst = 1'b0;
  endtask

  task automatic test_role_idle();
    player1_choose = 1; player2_choose = 1;
    repeat (4) @(negedge clk60MHz);
    compared++;
    if (allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL idle_both_high: got %h required 0", allOut);
    end
    player1_choose = 0; player2_choose = 0;
    repeat (4) @(negedge clk60MHz);
    compared++;
    if (allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL idle_both_low: got %h required 0", allOut);
    end
  endtask

  task automatic test_role_select();
    player1_choose = 1;
    @(negedge clk60MHz);
    compared++;
    if ({out_player1_ready, out_player2_ready, player1_led, player2_led} !== 4'b1010) begin
      mismatched++;
      $display("[TB] FAIL role_latch: got %b required 1010",
               {out_player1_ready, out_player2_ready, player1_led, player2_led});
    end
    player1_choose = 0;
    repeat (2) @(negedge clk60MHz);
    compared++;
    if ({out_player1_ready, out_player2_ready, player1_led, player2_led} !== 4'b1010) begin
      mismatched++;
      $display("[TB] FAIL role_held: got %b required 1010",
               {out_player1_ready, out_player2_ready, player1_led, player2_led});
    end
  endtask

  task automatic test_aim_hold();
    int starts, flags, s2, f2;
    mouse_left = 1'b1;
    in_player2_ready = 1'b1;
    run_cycles(20, starts, flags);
    mouse_left = 1'b0;
    run_cycles(6, s2, f2);
    compared++;
    if (starts + s2 + flags + f2 != 0) begin
      mismatched++;
      $display("[TB] FAIL aim_hold_no_charge: starts %0d flags %0d required 0 0", starts + s2, flags + f2);
    end
  endtask

  task automatic test_charge_saturation();
    logic [4:0] expP;
    bit seen;
    int highCnt;
    press_mouse(200, expP);
    compared++;
    if (ledy !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL sat_ledy: got %b required 1111", ledy);
    end
    expQ.push_back(expP);
    @(negedge clk60MHz);
    compared++;
    if ({out_power, out_throw_flag} !== {5'd31, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL sat_power_before_flag: got %0d/%b required 31/0", out_power, out_throw_flag);
    end
    wait_start(3, seen);
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL sat_start: no throw_start within budget, required one");
    end else begin
      if (throw_power !== expQ.pop_front()) begin
        mismatched++;
        $display("[TB] FAIL sat_throw_power: got %0d required 31", throw_power);
      end
    end
    highCnt = 0;
    for (int i = 0; i < FLAG_HOLD + 6; i++) begin
      if (out_throw_flag === 1'b1) highCnt++;
      else if (highCnt > 0) break;
      @(negedge clk60MHz);
    end
    compared++;
    if (highCnt != FLAG_HOLD) begin
      mismatched++;
      $display("[TB] FAIL sat_flag_width: got %0d cycles required %0d", highCnt, FLAG_HOLD);
    end
    compared++;
    if (out_power !== 5'd31) begin
      mismatched++;
      $display("[TB] FAIL sat_power_after_flag: got %0d required 31", out_power);
    end
    done_pulse(1'b0);
    compared++;
    if (turn !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_turn_toggle: got %b required 1", turn);
    end
  endtask

  task automatic test_remote_throw();
    bit seen;
    int starts, flags;
    in_power = 5'd17;
    expQ.push_back(5'd17);
    repeat (2) @(negedge clk60MHz);
    in_throw_flag = 1'b1;
    wait_start(3, seen);
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL remote_start: no throw_start within 3 cycles, required one");
    end else begin
      if (throw_power !== expQ.pop_front()) begin
        mismatched++;
        $display("[TB] FAIL remote_throw_power: got %0d required 17", throw_power);
      end
    end
    @(negedge clk60MHz);
    compared++;
    if (throw_start !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL remote_start_width: got %b required 0", throw_start);
    end
    in_throw_flag = 1'b0;
    in_power = 5'd3;
    repeat (3) @(negedge clk60MHz);
    in_throw_flag = 1'b1;
    run_cycles(6, starts, flags);
    compared++;
    if (starts != 0 || throw_power !== 5'd17) begin
      mismatched++;
      $display("[TB] FAIL remote_second_edge: starts %0d power %0d required 0 17", starts, throw_power);
    end
    in_throw_flag = 1'b0;
    repeat (3) @(negedge clk60MHz);
    done_pulse(1'b0);
    compared++;
    if (turn !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL remote_turn_toggle: got %b required 0", turn);
    end
  endtask

  task automatic test_local_throw();
    logic [4:0] expP;
    bit seen;
    int highCnt;
    press_mouse(39, expP);
    expQ.push_back(expP);
    @(negedge clk60MHz);
    compared++;
    if ({out_power, out_throw_flag} !== {5'd9, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL local_power_before_flag: got %0d/%b required 9/0", out_power, out_throw_flag);
    end
    wait_start(3, seen);
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL local_start: no throw_start within budget, required one");
    end else begin
      if (throw_power !== expQ.pop_front() || out_throw_flag !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL local_throw_power: got %0d flag %b required 9 1", throw_power, out_throw_flag);
      end
    end
    highCnt = 0;
    for (int i = 0; i < FLAG_HOLD + 6; i++) begin
      if (out_throw_flag === 1'b1) highCnt++;
      else if (highCnt > 0) break;
      @(negedge clk60MHz);
      compared++;
      if (throw_start !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL local_single_start: got %b required 0", throw_start);
      end
    end
    compared++;
    if (highCnt != FLAG_HOLD || out_power !== 5'd9) begin
      mismatched++;
      $display("[TB] FAIL local_flag_width: got %0d cycles power %0d required %0d 9", highCnt, out_power, FLAG_HOLD);
    end
    done_pulse(1'b1);
    compared++;
    if (turn !== 1'b1 || winner !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL local_hit_turn: got turn %b winner %b required 1 00", turn, winner);
    end
  endtask

  task automatic test_turn_and_win();
    logic [4:0] expP;
    bit seen;
    int starts, flags;
    for (int k = 2; k <= WIN_HITS; k++) begin
      in_power = 5'(k + 3);
      expQ.push_back(5'(k + 3));
      repeat (2) @(negedge clk60MHz);
      in_throw_flag = 1'b1;
      wait_start(3, seen);
      compared++;
      if (!seen || throw_power !== expQ.pop_front()) begin
        mismatched++;
        $display("[TB] FAIL win_remote_%0d: seen %b power %0d required 1 %0d", k, seen, throw_power, k + 3);
      end
      in_throw_flag = 1'b0;
      repeat (3) @(negedge clk60MHz);
      done_pulse(1'b0);
      compared++;
      if (turn !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL win_turn_after_miss_%0d: got %b required 0", k, turn);
      end
      press_mouse(4 * k + 2, expP);
      expQ.push_back(expP);
      wait_start(4, seen);
      compared++;
      if (!seen || throw_power !== expQ.pop_front()) begin
        mismatched++;
        $display("[TB] FAIL win_local_%0d: seen %b power %0d required 1 %0d", k, seen, throw_power, expP);
      end
      wait_flag_low(FLAG_HOLD + 4);
      done_pulse(1'b1);
      compared++;
      if (k < WIN_HITS) begin
        if (turn !== 1'b1 || winner !== 2'b00) begin
          mismatched++;
          $display("[TB] FAIL win_turn_after_hit_%0d: turn %b winner %b required 1 00", k, turn, winner);
        end
      end else begin
        if (winner !== 2'b01 || turn !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL win_declared: winner %b turn %b required 01 0", winner, turn);
        end
      end
    end
    done_pulse(1'b1);
    in_power = 5'd20;
    in_throw_flag = 1'b1;
    run_cycles(6, starts, flags);
    in_throw_flag = 1'b0;
    mouse_left = 1'b1;
    run_cycles(10, starts, flags);
    mouse_left = 1'b0;
    run_cycles(4, starts, flags);
    compared++;
    if (winner !== 2'b01 || turn !== 1'b0 || throw_start !== 1'b0 || out_throw_flag !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL game_over_frozen: winner %b turn %b start %b flag %b required 01 0 0 0",
               winner, turn, throw_start, out_throw_flag);
    end
  endtask

  task automatic test_reset_mid_throw();
    logic [4:0] expP;
    bit seen;
    rst = 1'b1;
    @(negedge clk60MHz);
    rst = 1'b0;
    player1_choose = 1'b1;
    @(negedge clk60MHz);
    player1_choose = 1'b0;
    repeat (4) @(negedge clk60MHz);
    press_mouse(9, expP);
    expQ.push_back(expP);
    wait_start(4, seen);
    compared++;
    if (!seen || throw_power !== expQ.pop_front()) begin
      mismatched++;
      $display("[TB] FAIL rst_test_throw: seen %b power %0d required 1 %0d", seen, throw_power, expP);
    end
    repeat (2) @(negedge clk60MHz);
    compared++;
    if (out_throw_flag !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_test_flag_high: got %b required 1", out_throw_flag);
    end
    rst = 1'b1;
    @(negedge clk60MHz);
    compared++;
    if (allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_throw: got %h required 0", allOut);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk60MHz);
    compared++;
    if (allOut !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_back_to_idle: got %h required 0", allOut);
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drained: got %0d pending required 0", expQ.size());
    end
  endtask

  initial begin
    $display("[TB] turn_ctl scenarios starting");
    test_reset();
    test_role_idle();
    test_role_select();
    test_aim_hold();
    test_charge_saturation();
    test_remote_throw();
    test_local_throw();
    test_turn_and_win();
    test_reset_mid_throw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
